vram_arbiter: RTL and testbench

Shares one single-port synchronous framebuffer RAM between the VGA display fetch path and two pixel writers (game logic, sprite engine). It sits between the VGA timing controller and the framebuffer RAM. It converts the controller's pixel coordinates into downscaled framebuffer addresses and returns pixel colour with the one-cycle lead the controller expects. Writers receive the RAM only in cycles when the display is not fetching, arbitrated round-robin. The block also publishes frame-start and vertical-blank status for game-logic sequencing.

---
 rtl/vram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous framebuffer RAM between
// the VGA display fetch path and two pixel writers. Display fetches always
// win; writers share the remaining cycles round-robin. Also publishes
// frame_start / vblank status derived from the fetch stream.
module vram_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic [15:0]       pix_data,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [15:0]       wr_data0,
    input  logic [15:0]       wr_data1,
    output logic [1:0]        wr_gnt,
    output logic              wr_drop,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic              frame_start,
    output logic              vblank
);

    // Wide enough for any 10-bit row index times a framebuffer width
    // below 2^14, so the fetch sum never wraps before truncation.
    localparam int SUM_W = 24;
    localparam logic [SUM_W-1:0] FB_SIZE = SUM_W'(FB_W * FB_H);
    localparam logic [9:0] NO_REQ = 10'h3ff;
    localparam logic [9:0] LAST_X = 10'd639;
    localparam logic [9:0] LAST_Y = 10'd479;

    // True when a writer address lies inside the framebuffer.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (SUM_W'(a) < FB_SIZE);
    endfunction

    logic              disp_rd_s;
    logic              first_pix_s;
    logic              last_pix_s;
    logic [SUM_W-1:0]  fb_x_s;
    logic [SUM_W-1:0]  fb_y_s;
    logic [SUM_W-1:0]  row_base_s;
    logic [SUM_W-1:0]  fetch_sum_s;
    logic [ADDR_W-1:0] fetch_addr_s;
    logic              unused_sum_bits_s;
    logic [1:0]        gnt_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [15:0]       sel_data_s;
    logic              sel_ok_s;

    logic              rr_ptr_r;
    logic              disp_rd_d1_r;
    logic              frame_start_r;
    logic              vblank_r;

    assign disp_rd_s   = (pix_x != NO_REQ) && (pix_y != NO_REQ);
    assign first_pix_s = disp_rd_s && (pix_x == 10'd0) && (pix_y == 10'd0);
    assign last_pix_s  = disp_rd_s && (pix_x == LAST_X) && (pix_y == LAST_Y);

    assign fb_x_s = SUM_W'(pix_x >> SCALE_SHIFT);
    assign fb_y_s = SUM_W'(pix_y >> SCALE_SHIFT);

    // Row base address: shift-add form for the 160-wide framebuffer,
    // generic multiply otherwise.
    generate
        if (FB_W == 160) begin : g_row_shift
            // Row base = y*128 + y*32.
            always_comb begin
                row_base_s = (fb_y_s << 7) + (fb_y_s << 5);
            end
        end else begin : g_row_mul
            // Row base = y * FB_W.
            always_comb begin
                row_base_s = fb_y_s * SUM_W'(FB_W);
            end
        end
    endgenerate

    assign fetch_sum_s       = row_base_s + fb_x_s;
    assign fetch_addr_s      = fetch_sum_s[ADDR_W-1:0];
    assign unused_sum_bits_s = ^fetch_sum_s[SUM_W-1:ADDR_W];

    // Round-robin writer choice; writers only compete when the display is idle.
    always_comb begin
        gnt_s = 2'b00;
        if (disp_rd_s) begin
            gnt_s = 2'b00;
        end else begin
            case (wr_req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = rr_ptr_r ? 2'b10 : 2'b01;
                default: gnt_s = 2'b00;
            endcase
        end
    end

    // Route the granted writer's address and data.
    always_comb begin
        sel_addr_s = wr_addr0;
        sel_data_s = wr_data0;
        if (gnt_s[1]) begin
            sel_addr_s = wr_addr1;
            sel_data_s = wr_data1;
        end else begin
            sel_addr_s = wr_addr0;
            sel_data_s = wr_data0;
        end
    end

    assign sel_ok_s = addr_in_range(sel_addr_s);

    // RAM port and writer-facing outputs; everything is held at zero in reset.
    always_comb begin
        wr_gnt    = 2'b00;
        wr_drop   = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 16'h0000;
        pix_data  = 16'h0000;
        if (!sys_rst_n) begin
            wr_gnt   = 2'b00;
            pix_data = 16'h0000;
        end else begin
            pix_data = disp_rd_d1_r ? ram_rdata : 16'h0000;
            if (disp_rd_s) begin
                ram_addr = fetch_addr_s;
            end else if (gnt_s != 2'b00) begin
                wr_gnt    = gnt_s;
                ram_addr  = sel_addr_s;
                ram_wdata = sel_data_s;
                ram_we    = sel_ok_s;
                wr_drop   = !sel_ok_s;
            end else begin
                ram_addr = '0;
            end
        end
    end

    // Favour the writer that was not served last; hold when nothing is granted.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rr_ptr_r <= 1'b0;
        end else if (gnt_s[0]) begin
            rr_ptr_r <= 1'b1;
        end else if (gnt_s[1]) begin
            rr_ptr_r <= 1'b0;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Remember that last cycle was a fetch so the read data is returned now.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_rd_d1_r <= 1'b0;
        end else begin
            disp_rd_d1_r <= disp_rd_s;
        end
    end

    // Frame status: pulse on the first active fetch, vblank after the last one.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_start_r <= 1'b0;
            vblank_r      <= 1'b1;
        end else begin
            frame_start_r <= first_pix_s;
            if (first_pix_s) begin
                vblank_r <= 1'b0;
            end else if (last_pix_s) begin
                vblank_r <= 1'b1;
            end else begin
                vblank_r <= vblank_r;
            end
        end
    end

    assign frame_start = frame_start_r;
    assign vblank      = vblank_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter with a behavioural reference model and
// a synchronous-read RAM model attached to the RAM port.
module tb_vram_arbiter;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] pix_data;
    logic [1:0]  wr_req;
    logic [14:0] wr_addr0, wr_addr1;
    logic [15:0] wr_data0, wr_data1;
    logic [1:0]  wr_gnt;
    logic        wr_drop;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        frame_start, vblank;

    int n_tests = 0;
    int n_fail  = 0;

    // Stored contents are XORed with an address hash so that a zero-filled
    // array represents a RAM whose words all differ.
    logic [15:0] ram     [0:32767] = '{default: 16'h0000};
    logic [15:0] ref_mem [0:32767] = '{default: 16'h0000};

    // Reference model state
    int m_fav = 0;
    bit m_pf  = 1'b0;
    int m_pa  = 0;
    bit m_fs  = 1'b0;
    bit m_vb  = 1'b1;

    always #20 vga_clk = ~vga_clk;

    vram_arbiter dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_gnt(wr_gnt), .wr_drop(wr_drop),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .frame_start(frame_start), .vblank(vblank)
    );

    function automatic logic [15:0] hash(input logic [14:0] a);
        return {a[7:0] ^ 8'h5a, a[14:7]};
    endfunction

    // Synchronous-read single-port RAM
    always @(posedge vga_clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata ^ hash(ram_addr);
        ram_rdata <= ram[ram_addr] ^ hash(ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input int x, input int y, input int req,
                         input int a0, input int d0, input int a1, input int d1);
        @(posedge vga_clk);
        #1;
        sys_rst_n = rst;
        pix_x = 10'(x); pix_y = 10'(y); wr_req = 2'(req);
        wr_addr0 = 15'(a0); wr_data0 = 16'(d0);
        wr_addr1 = 15'(a1); wr_data1 = 16'(d1);
    endtask

    // Compare every output against the model at the falling edge, then
    // advance the model to the state it holds after the next rising edge.
    task automatic step();
        bit fetch;
        int w, fa, sa, sd;
        logic [31:0] e_gnt, e_addr, e_we, e_wd, e_drop, e_pix, e_fs, e_vb;
        @(negedge vga_clk);
        fetch = 1'b0; fa = 0; w = 0;
        e_gnt = 0; e_addr = 0; e_we = 0; e_wd = 0; e_drop = 0; e_pix = 0;
        e_fs = m_fs; e_vb = m_vb;
        if (!sys_rst_n) begin
            e_fs = 0; e_vb = 1;
        end else begin
            fetch = (pix_x != 10'h3ff) && (pix_y != 10'h3ff);
            e_pix = m_pf ? 32'(ref_mem[m_pa] ^ hash(15'(m_pa))) : 0;
            if (fetch) begin
                fa = (((int'(pix_y) / 4) * 160) + (int'(pix_x) / 4)) % 32768;
                e_addr = fa;
            end else if (wr_req != 2'b00) begin
                if (wr_req == 2'b11) w = m_fav;
                else w = wr_req[1] ? 1 : 0;
                sa = (w == 1) ? int'(wr_addr1) : int'(wr_addr0);
                sd = (w == 1) ? int'(wr_data1) : int'(wr_data0);
                e_gnt = 1 << w;
                e_addr = sa; e_wd = sd;
                e_we = (sa < 19200) ? 1 : 0;
                e_drop = (sa < 19200) ? 0 : 1;
            end
        end
        chk("wr_gnt", 32'(wr_gnt), e_gnt);
        chk("ram_addr", 32'(ram_addr), e_addr);
        chk("ram_we", 32'(ram_we), e_we);
        chk("ram_wdata", 32'(ram_wdata), e_wd);
        chk("wr_drop", 32'(wr_drop), e_drop);
        chk("pix_data", 32'(pix_data), e_pix);
        chk("frame_start", 32'(frame_start), e_fs);
        chk("vblank", 32'(vblank), e_vb);
        if (!sys_rst_n) begin
            m_fav = 0; m_pf = 1'b0; m_fs = 1'b0; m_vb = 1'b1;
        end else begin
            if (e_gnt != 0) m_fav = 1 - w;
            if (e_we == 1) ref_mem[e_addr[14:0]] = e_wd[15:0] ^ hash(e_addr[14:0]);
            m_pf = fetch; m_pa = fa;
            m_fs = fetch && pix_x == 10'd0 && pix_y == 10'd0;
            if (m_fs) m_vb = 1'b0;
            else if (fetch && pix_x == 10'd639 && pix_y == 10'd479) m_vb = 1'b1;
        end
    endtask

    initial begin
        int r, x, y, a0, a1;
        sys_rst_n = 1'b0; pix_x = 10'h3ff; pix_y = 10'h3ff; wr_req = 2'b00;
        wr_addr0 = 15'd0; wr_addr1 = 15'd0; wr_data0 = 16'h0; wr_data1 = 16'h0;

        // Reset state
        drive(1'b0, 1023, 1023, 3, 1, 2, 3, 4); step();
        chk("rst_vblank", 32'(vblank), 32'd1);
        drive(1'b0, 1023, 1023, 3, 1, 2, 3, 4); step();

        // Both writers request during blanking: alternate from writer 0
        drive(1'b1, 1023, 1023, 3, 0, 16'hF800, 5, 16'h1234); step();
        chk("rr_g0", 32'(wr_gnt), 32'd1);
        chk("rr_we0", 32'(ram_we), 32'd1);
        drive(1'b1, 1023, 1023, 3, 7, 16'h0F0F, 6, 16'h4321); step();
        chk("rr_g1", 32'(wr_gnt), 32'd2);
        chk("rr_a1", 32'(ram_addr), 32'd6);
        drive(1'b1, 1023, 1023, 3, 8, 16'h1111, 9, 16'h2222); step();
        chk("rr_g2", 32'(wr_gnt), 32'd1);
        drive(1'b1, 1023, 1023, 3, 10, 16'h3333, 11, 16'h4444); step();
        chk("rr_g3", 32'(wr_gnt), 32'd2);

        // First pixel of the frame
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0); step();
        chk("fp_addr", 32'(ram_addr), 32'd0);
        drive(1'b1, 1023, 1023, 0, 0, 0, 0, 0); step();
        chk("fp_pix", 32'(pix_data), 32'hF800);
        chk("fp_fs", 32'(frame_start), 32'd1);
        chk("fp_vb", 32'(vblank), 32'd0);

        // Last pixel of the frame
        drive(1'b1, 639, 479, 0, 0, 0, 0, 0); step();
        chk("lp_addr", 32'(ram_addr), 32'd19199);
        drive(1'b1, 1023, 1023, 0, 0, 0, 0, 0); step();
        chk("lp_vb", 32'(vblank), 32'd1);
        chk("lp_fs", 32'(frame_start), 32'd0);
        drive(1'b1, 1023, 1023, 0, 0, 0, 0, 0); step();
        chk("lp_pix0", 32'(pix_data), 32'd0);

        // Writer 1 starved by active fetches, granted on first idle cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 100, 50, 2, 0, 0, 300, 16'hABCD); step();
            chk("st_gnt", 32'(wr_gnt), 32'd0);
            chk("st_we", 32'(ram_we), 32'd0);
        end
        drive(1'b1, 1023, 1023, 2, 0, 0, 300, 16'hABCD); step();
        chk("st_gnt_idle", 32'(wr_gnt), 32'd2);

        // Out-of-range write is granted but dropped
        drive(1'b1, 1023, 1023, 1, 19200, 16'h5555, 0, 0); step();
        chk("oor_gnt", 32'(wr_gnt), 32'd1);
        chk("oor_we", 32'(ram_we), 32'd0);
        chk("oor_drop", 32'(wr_drop), 32'd1);
        drive(1'b1, 1023, 1023, 0, 0, 0, 0, 0); step();
        chk("oor_drop_end", 32'(wr_drop), 32'd0);

        // Reset mid-line with both writers requesting (writer 1 is favoured now)
        drive(1'b0, 20, 20, 3, 12, 16'h6666, 13, 16'h7777); step();
        chk("mr_gnt", 32'(wr_gnt), 32'd0);
        chk("mr_vb", 32'(vblank), 32'd1);
        drive(1'b0, 1023, 1023, 3, 12, 16'h6666, 13, 16'h7777); step();
        drive(1'b1, 1023, 1023, 3, 12, 16'h6666, 13, 16'h7777); step();
        chk("mr_first", 32'(wr_gnt), 32'd1);

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      begin x = 1023; y = 1023; end
            else if (r < 40) begin x = 0; y = 0; end
            else if (r < 44) begin x = 639; y = 479; end
            else if (r < 48) begin x = 1023; y = $urandom_range(0, 479); end
            else if (r < 52) begin x = $urandom_range(0, 1022); y = $urandom_range(0, 1022); end
            else             begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
            a0 = ($urandom_range(0, 9) == 0) ? $urandom_range(19200, 32767) : $urandom_range(0, 19199);
            a1 = ($urandom_range(0, 9) == 0) ? $urandom_range(19200, 32767) : $urandom_range(0, 19199);
            drive(($urandom_range(0, 299) != 0), x, y, $urandom_range(0, 3),
                  a0, $urandom_range(0, 65535), a1, $urandom_range(0, 65535));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
